// File: rtl/serial_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// serial_transmitter_pkg
//
// Shared definitions for the 8N1 serial link. The transmitter and the matching
// receiver both import this package. The default bit period lives here so the
// two ends of the link cannot be built with different timing.
//
// Contents:
//   DEFAULT_FREQUENCY : clocks per serial bit used when not overridden
//   DATA_WIDTH        : bits per serial character
//   data_t            : one serial character
//   tx_state_e        : transmit FSM state encoding
// -----------------------------------------------------------------------------
package serial_transmitter_pkg;

  localparam int DEFAULT_FREQUENCY = 87;
  localparam int DATA_WIDTH        = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // The encodings are fixed so the state can be probed and compared with the
  // receiver side when debugging.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage : serial_transmitter_pkg

// File: rtl/serial_transmitter_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
//
// Synchronous byte FIFO. It supports a write and a pop on the same edge. A
// write is dropped when the FIFO is full, and a pop is dropped when it is
// empty. When the FIFO is full, a write is not accepted even if a pop happens
// on the same edge, so there is never any write-through.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset; empties the FIFO
//   wr_en    : write request
//   wr_data  : byte to store on a write
//   rd_en    : pop request
//   rd_data  : head of the FIFO (valid while !empty)
//   full     : FIFO holds DEPTH entries
//   empty    : FIFO holds no entries
//   level    : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module byte_fifo
  import serial_transmitter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  data_t         wr_data,
  input  logic          rd_en,
  output data_t         rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  data_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Entries are only read after they
  // have been written, and leaving them unreset keeps the array in plain RAM
  // cells.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule : byte_fifo

// File: rtl/serial_transmitter.sv
// -----------------------------------------------------------------------------
// serial_transmitter
//
// Buffered 8N1 serial transmitter. Bytes enter through a valid/ready handshake
// into a byte FIFO. Each byte is sent as one start bit (0), then eight data
// bits LSB first, then one stop bit (1). Every bit lasts FREQUENCY clocks.
// When bytes are queued, the next start bit follows the stop bit directly,
// with no idle time between frames.
//
// Parameters:
//   FREQUENCY  : clocks per bit, 2..255; must match the receiver
//   FIFO_DEPTH : byte FIFO entries, power of two, 2..16
//
// Ports:
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset; forces the line high
//   i_DV          : byte valid; written when i_DV && o_Ready at a clock edge
//   i_Byte        : byte to send, sampled only on a write
//   o_Ready       : FIFO not full
//   o_Serial_Data : registered serial line, idle high
//   o_Active      : high from the start bit through the stop bit
//   o_Done        : one-cycle pulse after each stop bit completes
//   o_Level       : FIFO occupancy
// -----------------------------------------------------------------------------
module serial_transmitter
  import serial_transmitter_pkg::*;
#(
  parameter  int FREQUENCY  = DEFAULT_FREQUENCY,
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_DV,
  input  data_t         i_Byte,
  output logic          o_Ready,
  output logic          o_Serial_Data,
  output logic          o_Active,
  output logic          o_Done,
  output logic [LW-1:0] o_Level
);

  // The counter runs 0..FREQUENCY-1, so $clog2(FREQUENCY) bits always hold it.
  localparam int          CW       = $clog2(FREQUENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(FREQUENCY - 1);

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic  fifo_pop;
  logic  fifo_full;
  logic  fifo_empty;
  data_t fifo_head;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (i_DV),
    .wr_data (i_Byte),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_Level)
  );

  assign o_Ready = !fifo_full;

  // ---------------------------------------------------------------------------
  // Transmit FSM state and datapath
  // ---------------------------------------------------------------------------
  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  data_t         shreg_q, shreg_d;
  logic          line_q,  line_d;
  logic          active_q, active_d;
  logic          done_q,  done_d;

  logic          bit_end;
  logic [2:0]    idx_next;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign idx_next = idx_q + 3'd1;

  // The line is a register, and its reset value is 1. A reset therefore
  // returns the line to idle at once, even in the middle of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      line_q   <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      line_q   <= line_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement.
  // Without those defaults, a path that skips an assignment would infer a
  // latch. The block uses blocking assignments because it models logic, not
  // storage.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    line_d   = line_q;
    active_d = active_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        line_d   = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          line_d   = 1'b0;
          active_d = 1'b1;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          line_d  = shreg_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            line_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            idx_d  = idx_next;
            line_d = shreg_q[idx_next];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          idx_d  = '0;
          done_d = 1'b1;
          // If another byte is queued, its start bit follows the stop bit
          // directly. Otherwise the line stays high and the FSM goes idle.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head;
            line_d   = 1'b0;
            active_d = 1'b1;
            state_d  = ST_START;
          end else begin
            line_d   = 1'b1;
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        line_d   = 1'b1;
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign o_Serial_Data = line_q;
  assign o_Active      = active_q;
  assign o_Done        = done_q;

endmodule : serial_transmitter

// File: tb/tb_serial_transmitter.sv
// -----------------------------------------------------------------------------
// tb_serial_transmitter
//
// Directed bench for serial_transmitter. It instantiates one copy with
// FREQUENCY=87 and one with FREQUENCY=2. Inputs are driven and outputs are
// sampled 1 ns after each rising clock edge. The expected frame bits come from
// the byte value, following the 8N1 framing rules.
// -----------------------------------------------------------------------------
module tb_serial_transmitter;

  logic       clk;
  logic       rst;

  logic       dv87, dv2;
  logic [7:0] byte87, byte2;
  logic       ready87, ready2;
  logic       line87, line2;
  logic       active87, active2;
  logic       done87, done2;
  logic [2:0] level87, level2;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt87 = 0;

  // Selects which instance the shared frame checker observes.
  bit   use2 = 1'b0;
  logic line_s, active_s, done_s;
  assign line_s   = use2 ? line2   : line87;
  assign active_s = use2 ? active2 : active87;
  assign done_s   = use2 ? done2   : done87;

  serial_transmitter #(.FREQUENCY(87), .FIFO_DEPTH(4)) dut87 (
    .clk           (clk),
    .rst           (rst),
    .i_DV          (dv87),
    .i_Byte        (byte87),
    .o_Ready       (ready87),
    .o_Serial_Data (line87),
    .o_Active      (active87),
    .o_Done        (done87),
    .o_Level       (level87)
  );

  serial_transmitter #(.FREQUENCY(2), .FIFO_DEPTH(4)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .i_DV          (dv2),
    .i_Byte        (byte2),
    .o_Ready       (ready2),
    .o_Serial_Data (line2),
    .o_Active      (active2),
    .o_Done        (done2),
    .o_Level       (level2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (done87) done_cnt87++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call this 1 ns after the edge that drives the start bit. It checks all ten
  // bits at both the first and the last cycle of each bit. It then checks the
  // o_Done pulse and what follows it. When queued=1, the task returns at the
  // start bit of the next frame, so frames can be checked back to back.
  task automatic expect_frame(input logic [7:0] b, input bit queued);
    int   f;
    logic e;
    f = use2 ? 2 : 87;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      check($sformatf("b%02h_bit%0d_first", b, k), line_s, e);
      check($sformatf("b%02h_active%0d", b, k), active_s, 1'b1);
      repeat (f - 1) tick();
      check($sformatf("b%02h_bit%0d_last", b, k), line_s, e);
      check($sformatf("b%02h_nodone%0d", b, k), done_s, 1'b0);
      tick();
    end
    check($sformatf("b%02h_done", b), done_s, 1'b1);
    check($sformatf("b%02h_after_line", b), line_s, !queued);
    check($sformatf("b%02h_after_active", b), active_s, queued);
    if (!queued) begin
      tick();
      check($sformatf("b%02h_done_once", b), done_s, 1'b0);
      check($sformatf("b%02h_idle_line", b), line_s, 1'b1);
    end
  endtask

  logic [7:0] fill [6];
  bit         low_seen;
  int         done_before;

  initial begin
    fill[0] = 8'h81; fill[1] = 8'h42; fill[2] = 8'h24;
    fill[3] = 8'h18; fill[4] = 8'hC3; fill[5] = 8'h99;
    rst = 1'b1;
    dv87 = 1'b0; byte87 = 8'h00;
    dv2  = 1'b0; byte2  = 8'h00;
    #1;
    check("rst_line", line87, 1'b1);
    tick(); tick();
    rst = 1'b0;

    // ---- Reset state, then 1000 idle clocks
    repeat (1000) tick();
    check("idle_line",   line87,   1'b1);
    check("idle_ready",  ready87,  1'b1);
    check("idle_level",  level87,  3'd0);
    check("idle_active", active87, 1'b0);
    check("idle_done",   done_cnt87, 0);

    // ---- Single frame 0xA5
    dv87 = 1'b1; byte87 = 8'hA5;
    tick();                                   // edge N
    dv87 = 1'b0; byte87 = 8'hFF;              // later changes must not matter
    check("a5_level_n",  level87, 3'd1);
    check("a5_line_n",   line87,  1'b1);
    tick();                                   // edge T = N+1
    check("a5_level_t",  level87, 3'd0);
    expect_frame(8'hA5, 1'b0);

    // ---- Burst 0x00, 0xFF, 0x55, 0x3C
    dv87 = 1'b1; byte87 = 8'h00;
    tick();
    byte87 = 8'hFF;
    tick();                                   // T: 0x00 popped, 0xFF written
    check("burst_level_t", level87, 3'd1);
    fork
      begin
        byte87 = 8'h55; tick();
        byte87 = 8'h3C; tick();
        dv87 = 1'b0;
        check("burst_level_full3", level87, 3'd3);
      end
    join_none
    expect_frame(8'h00, 1'b1);
    check("burst_level_1", level87, 3'd2);
    expect_frame(8'hFF, 1'b1);
    check("burst_level_2", level87, 3'd1);
    expect_frame(8'h55, 1'b1);
    check("burst_level_3", level87, 3'd0);
    expect_frame(8'h3C, 1'b0);

    // ---- FIFO fill: i_DV held high for six consecutive edges
    dv87 = 1'b1; byte87 = fill[0];
    tick();                                   // N
    check("fill_level_n", level87, 3'd1);
    byte87 = fill[1];
    tick();                                   // N+1: fill[0] pops
    check("fill_level_n1", level87, 3'd1);
    check("fill_line_n1",  line87,  1'b0);
    fork
      begin
        byte87 = fill[2]; tick();
        check("fill_level_n2", level87, 3'd2);
        byte87 = fill[3]; tick();
        byte87 = fill[4]; tick();             // N+4 fills the FIFO
        check("fill_level_full", level87, 3'd4);
        check("fill_ready_low",  ready87,  1'b0);
        byte87 = fill[5]; tick();             // N+5 ignored
        check("fill_level_ignored", level87, 3'd4);
        dv87 = 1'b0;
      end
    join_none
    for (int i = 0; i < 5; i++) expect_frame(fill[i], i < 4);
    low_seen = 1'b0;
    repeat (300) begin
      tick();
      if (!line87) low_seen = 1'b1;
    end
    check("fill_sixth_not_sent", low_seen, 1'b0);
    check("fill_level_end", level87, 3'd0);

    // ---- Reset during the DATA bits of the second of three queued bytes
    dv87 = 1'b1; byte87 = 8'h0F;
    tick();
    byte87 = 8'hF0;
    tick();
    fork
      begin
        byte87 = 8'h5A; tick();
        dv87 = 1'b0;
      end
    join_none
    expect_frame(8'h0F, 1'b1);
    repeat (87 * 3 + 40) tick();
    check("rst_mid_active_before", active87, 1'b1);
    check("rst_mid_level_before",  level87,  3'd1);
    done_before = done_cnt87;
    #3 rst = 1'b1;
    #1;
    check("rst_mid_line",   line87,   1'b1);
    check("rst_mid_level",  level87,  3'd0);
    check("rst_mid_active", active87, 1'b0);
    check("rst_mid_ready",  ready87,  1'b1);
    tick(); tick();
    rst = 1'b0;
    low_seen = 1'b0;
    repeat (2000) begin
      tick();
      if (!line87) low_seen = 1'b1;
    end
    check("rst_no_more_frames", low_seen, 1'b0);
    check("rst_no_done", done_cnt87, done_before);
    dv87 = 1'b1; byte87 = 8'hC6;
    tick();
    dv87 = 1'b0;
    tick();
    expect_frame(8'hC6, 1'b0);

    // ---- FREQUENCY=2, byte 0x80
    use2 = 1'b1;
    dv2 = 1'b1; byte2 = 8'h80;
    tick();
    dv2 = 1'b0;
    check("f2_level_n", level2, 3'd1);
    tick();
    expect_frame(8'h80, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_transmitter
